// File: rtl/pp_pipeline_accel_div_pkg.sv
// Shared widths, FSM state encoding and iteration-counter sizing for the
// sequential signed divider.
package pp_pipeline_accel_div_pkg;

  localparam int DIVIDEND_W_DEF = 17;
  localparam int DIVISOR_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // The counter must reach DIVIDEND_W-1, so one extra code is reserved.
  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

  localparam int CNT_W_DEF = $clog2(DIVIDEND_W_DEF + 1);

endpackage

// File: rtl/pp_pipeline_accel_sdiv_17s_8s_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// The divider takes the slave side; the producer/consumer takes the master side.
interface pp_pipeline_accel_sdiv_17s_8s_seq_if #(
  parameter int DIVIDEND_W = pp_pipeline_accel_div_pkg::DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = pp_pipeline_accel_div_pkg::DIVISOR_W_DEF
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] din0;
  logic signed [DIVISOR_W-1:0]  din1;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DIVIDEND_W-1:0] quot;
  logic signed [DIVISOR_W-1:0]  rem;
  logic                         div_by_zero;
  logic                         ovf;

  modport master (
    output in_valid,
    output din0,
    output din1,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quot,
    input  rem,
    input  div_by_zero,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  din0,
    input  din1,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quot,
    output rem,
    output div_by_zero,
    output ovf
  );

endinterface

// File: rtl/pp_pipeline_accel_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes: shift in the next
// dividend bit, subtract the divisor when it fits and report the quotient bit.
module pp_pipeline_accel_div_step
  import pp_pipeline_accel_div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   prem,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] dmag,
  output logic [DIVISOR_W:0]   prem_next,
  output logic                 qbit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] diff;

  // A set top bit of the incoming remainder means the shifted value already
  // exceeds any divisor magnitude, so the subtract must happen regardless.
  always_comb begin
    shifted   = {prem[DIVISOR_W-1:0], next_bit};
    diff      = shifted - {1'b0, dmag};
    qbit      = prem[DIVISOR_W] | (shifted >= {1'b0, dmag});
    prem_next = qbit ? diff : shifted;
  end

endmodule

// File: rtl/pp_pipeline_accel_sdiv_17s_8s_seq.sv
// Sequential signed divider: one restoring step per cycle on magnitudes, sign fix-up
// in a single cycle afterwards. Remainder is produced only with PP_PIPELINE_ACCEL_DIV_REM_EN.
module pp_pipeline_accel_sdiv_17s_8s_seq
  import pp_pipeline_accel_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  pp_pipeline_accel_sdiv_17s_8s_seq_if.slave bus
);

  localparam int                  CW       = cnt_width(DIVIDEND_W);
  localparam logic [CW-1:0]         LAST     = CW'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] MIN_DVD  = {1'b1, {(DIVIDEND_W-1){1'b0}}};
  localparam logic [DIVIDEND_W-1:0] MAX_QUOT = {1'b0, {(DIVIDEND_W-1){1'b1}}};

  div_state_t state_q, state_d;

  logic                  accept;
  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dsr_mag;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dmag_q;
  logic [DIVISOR_W:0]    prem_q;
  logic [DIVISOR_W:0]    prem_next;
  logic                  qbit;
  logic [CW-1:0]         cnt_q;
  logic                  negq_q;
  logic                  zero_q;
  logic                  sat_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic                  dbz_q;
  logic                  ovf_q;

  assign accept = (state_q == IDLE) && bus.in_valid;

  always_comb begin
    dvd_mag = bus.din0[DIVIDEND_W-1] ? -bus.din0 : bus.din0;
    dsr_mag = bus.din1[DIVISOR_W-1]  ? -bus.din1 : bus.din1;
  end

  pp_pipeline_accel_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem      (prem_q),
    .next_bit  (dvd_q[DIVIDEND_W-1]),
    .dmag      (dmag_q),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Ready/valid are pure state decodes, so DONE exiting can never overlap an accept.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient register: each step shifts
  // out one dividend bit at the top and shifts in one quotient bit at the bottom.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      dvd_q  <= '0;
      dmag_q <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      negq_q <= 1'b0;
      zero_q <= 1'b0;
      sat_q  <= 1'b0;
      quot_q <= '0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_q  <= dvd_mag;
            dmag_q <= dsr_mag;
            prem_q <= '0;
            cnt_q  <= '0;
            negq_q <= bus.din0[DIVIDEND_W-1] ^ bus.din1[DIVISOR_W-1];
            zero_q <= (bus.din1 == '0);
            sat_q  <= (bus.din0 == MIN_DVD) && (bus.din1 == '1);
          end
        end
        CALC: begin
          dvd_q  <= {dvd_q[DIVIDEND_W-2:0], qbit};
          prem_q <= prem_next;
          cnt_q  <= cnt_q + CW'(1);
        end
        FIX: begin
          if (zero_q)      quot_q <= '1;
          else if (sat_q)  quot_q <= MAX_QUOT;
          else if (negq_q) quot_q <= -dvd_q;
          else             quot_q <= dvd_q;
          dbz_q <= zero_q;
          ovf_q <= sat_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.quot        = quot_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.ovf         = ovf_q;

`ifdef PP_PIPELINE_ACCEL_DIV_REM_EN
  logic                 negr_q;
  logic [DIVISOR_W-1:0] rem_q;

  // Remainder takes the dividend's sign; the final partial remainder always fits DIVISOR_W bits.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      negr_q <= 1'b0;
      rem_q  <= '0;
    end else if (accept) begin
      negr_q <= bus.din0[DIVIDEND_W-1];
    end else if (state_q == FIX) begin
      if (zero_q || sat_q) rem_q <= '0;
      else if (negr_q)     rem_q <= -prem_q[DIVISOR_W-1:0];
      else                 rem_q <= prem_q[DIVISOR_W-1:0];
    end
  end

  assign bus.rem = rem_q;
`else
  assign bus.rem = '0;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_sdiv_17s_8s_seq.sv
// Self-checking bench for the sequential signed divider; expected results come from
// plain integer division in a reference function.
module tb_pp_pipeline_accel_sdiv_17s_8s_seq;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int   nvec = 0;
  int   nerr = 0;

  pp_pipeline_accel_sdiv_17s_8s_seq_if #(.DIVIDEND_W(17), .DIVISOR_W(8)) bus ();

  pp_pipeline_accel_sdiv_17s_8s_seq #(
    .DIVIDEND_W (17),
    .DIVISOR_W  (8)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  // Latency counts the accepting edge as edge 1 and the edge that raises out_valid as edge 19.
  localparam int EXP_LAT = 19;

  function automatic void model(input int a, input int b,
                                output logic signed [16:0] q, output logic signed [7:0] r,
                                output logic z, output logic o);
    if (b == 0) begin
      q = -17'sd1; r = '0; z = 1'b1; o = 1'b0;
    end else if (a == -65536 && b == -1) begin
      q = 17'sd65535; r = '0; z = 1'b0; o = 1'b1;
    end else begin
      q = 17'(a / b); r = 8'(a % b); z = 1'b0; o = 1'b0;
    end
`ifndef PP_PIPELINE_ACCEL_DIV_REM_EN
    r = '0;
`endif
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that raised out_valid, with out_ready low.
  task automatic do_op(input logic signed [16:0] a, input logic signed [7:0] b,
                       output int lat, output bit got);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge ap_clk); #1; guard++;
    end
    bus.din0 = a; bus.din1 = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    bus.din0 = 17'($urandom); bus.din1 = 8'($urandom);
    lat = 1; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge ap_clk); #1; lat++;
      if (bus.out_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.din0 = '0; bus.din1 = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    nvec++; if (bus.quot !== 17'sd0) begin nerr++; $display("[TB] FAIL reset quot: got %0d expected 0", bus.quot); end
    nvec++; if (bus.rem !== 8'sd0) begin nerr++; $display("[TB] FAIL reset rem: got %0d expected 0", bus.rem); end
    nvec++; if (bus.div_by_zero !== 1'b0) begin nerr++; $display("[TB] FAIL reset div_by_zero: got %b expected 0", bus.div_by_zero); end
    nvec++; if (bus.ovf !== 1'b0) begin nerr++; $display("[TB] FAIL reset ovf: got %b expected 0", bus.ovf); end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_directed();
    int da[8];
    int db[8];
    int lat;
    bit got;
    logic signed [16:0] eq;
    logic signed [7:0] er;
    logic ez, eo;
    da = '{100, -100, 100, -100, -65536, 1234, 65535, -65536};
    db = '{7, 7, -7, -7, -1, 0, -128, 1};
    for (int i = 0; i < 8; i++) begin
      model(da[i], db[i], eq, er, ez, eo);
      do_op(17'(da[i]), 8'(db[i]), lat, got);
      nvec++;
      if (!got) begin
        nerr++; $display("[TB] FAIL directed timeout %0d/%0d: got no out_valid expected one", da[i], db[i]);
      end else begin
        if (lat !== EXP_LAT) begin nerr++; $display("[TB] FAIL directed latency %0d/%0d: got %0d expected %0d", da[i], db[i], lat, EXP_LAT); end
        nvec++; if (bus.quot !== eq) begin nerr++; $display("[TB] FAIL directed quot %0d/%0d: got %0d expected %0d", da[i], db[i], bus.quot, eq); end
        nvec++; if (bus.rem !== er) begin nerr++; $display("[TB] FAIL directed rem %0d/%0d: got %0d expected %0d", da[i], db[i], bus.rem, er); end
        nvec++; if (bus.div_by_zero !== ez) begin nerr++; $display("[TB] FAIL directed dbz %0d/%0d: got %b expected %b", da[i], db[i], bus.div_by_zero, ez); end
        nvec++; if (bus.ovf !== eo) begin nerr++; $display("[TB] FAIL directed ovf %0d/%0d: got %b expected %b", da[i], db[i], bus.ovf, eo); end
      end
      release_result();
    end
  endtask

  task automatic test_random();
    int lat;
    bit got;
    logic signed [16:0] a;
    logic signed [7:0] b;
    logic signed [16:0] eq;
    logic signed [7:0] er;
    logic ez, eo;
    int sel;
    for (int i = 0; i < 40; i++) begin
      a = 17'($urandom); b = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 17'h10000; b = -8'sd1; end
      else if (sel == 2) b = -8'sd1;
      else if (sel == 3) a = 17'h10000;
      else if (sel == 4) a = 17'($urandom_range(0, 300));
      model(int'(a), int'(b), eq, er, ez, eo);
      do_op(a, b, lat, got);
      nvec++;
      if (!got) begin
        nerr++; $display("[TB] FAIL random timeout %0d/%0d: got no out_valid expected one", a, b);
      end else if (lat !== EXP_LAT || bus.quot !== eq || bus.rem !== er || bus.div_by_zero !== ez || bus.ovf !== eo) begin
        nerr++;
        $display("[TB] FAIL random %0d/%0d: got lat=%0d q=%0d r=%0d z=%b o=%b expected lat=%0d q=%0d r=%0d z=%b o=%b",
                 a, b, lat, bus.quot, bus.rem, bus.div_by_zero, bus.ovf, EXP_LAT, eq, er, ez, eo);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit got;
    logic signed [16:0] eq;
    logic signed [7:0] er;
    logic ez, eo;
    model(100, 7, eq, er, ez, eo);
    do_op(17'sd100, 8'sd7, lat, got);
    nvec++; if (!got) begin nerr++; $display("[TB] FAIL hold timeout: got no out_valid expected one"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1;
      nvec++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quot !== eq || bus.rem !== er ||
          bus.div_by_zero !== 1'b0 || bus.ovf !== 1'b0) begin
        nerr++;
        $display("[TB] FAIL hold cycle %0d: got v=%b rdy=%b q=%0d r=%0d expected v=1 rdy=0 q=%0d r=%0d",
                 i, bus.out_valid, bus.in_ready, bus.quot, bus.rem, eq, er);
      end
    end
    bus.out_ready = 1'b1; bus.din0 = -17'sd300; bus.din1 = 8'sd11; bus.in_valid = 1'b1;
    @(posedge ap_clk); #1;
    bus.out_ready = 1'b0;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      nerr++; $display("[TB] FAIL done exit: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL b2b accept: got rdy=%b expected 0", bus.in_ready); end
    lat = 1; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge ap_clk); #1; lat++;
      if (bus.out_valid === 1'b1) got = 1'b1;
    end
    model(-300, 11, eq, er, ez, eo);
    nvec++;
    if (!got || lat !== EXP_LAT || bus.quot !== eq || bus.rem !== er) begin
      nerr++; $display("[TB] FAIL b2b result: got lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d",
                       lat, bus.quot, bus.rem, EXP_LAT, eq, er);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit got;
    bit seen;
    logic signed [16:0] eq;
    logic signed [7:0] er;
    logic ez, eo;
    bus.din0 = 17'sd1000; bus.din1 = 8'sd3; bus.in_valid = 1'b1;
    @(posedge ap_clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    nvec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quot !== 17'sd0 || bus.rem !== 8'sd0 ||
        bus.div_by_zero !== 1'b0 || bus.ovf !== 1'b0) begin
      nerr++; $display("[TB] FAIL midreset outputs: got v=%b rdy=%b q=%0d r=%0d z=%b o=%b expected v=0 rdy=1 q=0 r=0 z=0 o=0",
                       bus.out_valid, bus.in_ready, bus.quot, bus.rem, bus.div_by_zero, bus.ovf);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge ap_clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    nvec++; if (seen) begin nerr++; $display("[TB] FAIL midreset stray out_valid: got 1 expected 0"); end
    model(50, 5, eq, er, ez, eo);
    do_op(17'sd50, 8'sd5, lat, got);
    nvec++;
    if (!got || lat !== EXP_LAT || bus.quot !== eq || bus.rem !== er || bus.div_by_zero !== 1'b0 || bus.ovf !== 1'b0) begin
      nerr++; $display("[TB] FAIL post-reset 50/5: got lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d",
                       lat, bus.quot, bus.rem, EXP_LAT, eq, er);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
